// File: rtl/cdc_handshake_tx.sv
// Source-domain sender for a multi-bit CDC: holds a word on TX_DATA, signals it
// with a two-phase TX_REQ toggle and waits for the resynchronized ACK toggle.
module cdc_handshake_tx #(
  parameter int unsigned NUM_STAGES  = 2,
  parameter int unsigned BUS_WIDTH   = 8,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] IN_DATA,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [BUS_WIDTH-1:0] TX_DATA,
  output logic                 TX_REQ,
  input  logic                 ACK_ASYNC,
  output logic                 DONE,
  output logic                 ERR
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_ACK = 1'b1;

  logic [0:0]            state;
  logic [NUM_STAGES-1:0] ack_sr;
  logic                  ack_sync;
  logic                  ack_match;
  logic [CNT_W-1:0]      cnt;

  // Stage 0 is the LSB; only the last stage is ever consumed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) ack_sr <= '0;
    else      ack_sr <= {ack_sr[NUM_STAGES-2:0], ACK_ASYNC};
  end

  assign ack_sync  = ack_sr[NUM_STAGES-1];
  assign ack_match = (ack_sync == TX_REQ);
  assign IN_READY  = (state == ST_IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= ST_IDLE;
      TX_DATA <= '0;
      TX_REQ  <= 1'b0;
      cnt     <= '0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state == ST_IDLE) begin
        // An ACK toggle with no request outstanding is a protocol violation.
        if (!ack_match) ERR <= 1'b1;
        if (IN_VALID) begin
          TX_DATA <= IN_DATA;
          TX_REQ  <= ~TX_REQ;
          cnt     <= '0;
          state   <= ST_WAIT_ACK;
        end
      end else begin
        if (ack_match) begin
          state <= ST_IDLE;
          DONE  <= 1'b1;
        end else begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
          // Flag only; a two-phase request cannot be retracted, so keep waiting.
          if (TIMEOUT_CYC != 0 && cnt == CNT_MAX - 1'b1) ERR <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Self-checking bench for cdc_handshake_tx: table-driven transfers, randomized
// transfers against a timeline model, plus timeout, spurious-ACK and reset cases.
module tb_cdc_handshake_tx;

  localparam int unsigned NS  = 2;
  localparam int unsigned BW  = 8;
  localparam int unsigned TMO = 10;

  logic          CLK;
  logic          RST;
  logic [BW-1:0] IN_DATA;
  logic          IN_VALID;
  logic          IN_READY;
  logic [BW-1:0] TX_DATA;
  logic          TX_REQ;
  logic          ACK_ASYNC;
  logic          DONE;
  logic          ERR;

  cdc_handshake_tx #(.NUM_STAGES(NS), .BUS_WIDTH(BW), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .TX_DATA(TX_DATA), .TX_REQ(TX_REQ),
    .ACK_ASYNC(ACK_ASYNC), .DONE(DONE), .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: number of launches since reset fixes the request level.
  int unsigned launches = 0;

  typedef struct {
    logic [BW-1:0] data;
    int unsigned   ack_dly;
    logic          vhold;
    logic          exp_req;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_req", {31'b0, TX_REQ}, 0);
    chk("rst_tx_data", {24'b0, TX_DATA}, 0);
    chk("rst_done", {31'b0, DONE}, 0);
    chk("rst_err", {31'b0, ERR}, 0);
    chk("rst_ready", {31'b0, IN_READY}, 1);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    ACK_ASYNC = 1'b0;
    IN_VALID = 1'b0;
    #1;
    chk_reset_vals();
    step();
    step();
    RST = 1'b1;
    launches = 0;
  endtask

  // One transfer: accept at the next edge, ACK toggled dly edges later, DONE
  // expected NS edges after the edge that first samples the ACK.
  task automatic xfer(input logic [BW-1:0] w, input int unsigned dly,
                      input logic vhold, input logic exp_req);
    IN_DATA  = w;
    IN_VALID = 1'b1;
    chk("ready_before_accept", {31'b0, IN_READY}, 1);
    step();
    launches++;
    chk("launch_data", {24'b0, TX_DATA}, {24'b0, w});
    chk("launch_req", {31'b0, TX_REQ}, {31'b0, exp_req});
    chk("launch_ready", {31'b0, IN_READY}, 0);
    chk("done_one_cycle", {31'b0, DONE}, 0);
    IN_VALID = vhold;
    for (int unsigned i = 0; i < dly + NS; i++) begin
      if (i == dly) ACK_ASYNC = exp_req;
      IN_DATA = BW'($urandom);
      step();
      chk("wait_data_stable", {24'b0, TX_DATA}, {24'b0, w});
      chk("wait_req_stable", {31'b0, TX_REQ}, {31'b0, exp_req});
      chk("wait_no_done", {31'b0, DONE}, 0);
      chk("wait_not_ready", {31'b0, IN_READY}, 0);
    end
    step();
    chk("done_pulse", {31'b0, DONE}, 1);
    chk("done_ready", {31'b0, IN_READY}, 1);
    chk("done_data", {24'b0, TX_DATA}, {24'b0, w});
    chk("done_no_err", {31'b0, ERR}, 0);
  endtask

  task automatic idle_gap(input int unsigned n);
    IN_VALID = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      IN_DATA = BW'($urandom);
      step();
      chk("gap_no_done", {31'b0, DONE}, 0);
      chk("gap_ready", {31'b0, IN_READY}, 1);
      chk("gap_req", {31'b0, TX_REQ}, {31'b0, launches[0]});
      chk("gap_no_err", {31'b0, ERR}, 0);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [BW-1:0] w;
    int unsigned   d;
    logic          h;

    vecs[0] = '{8'hA5, 3, 1'b0, 1'b1};
    vecs[1] = '{8'h01, 2, 1'b1, 1'b0};
    vecs[2] = '{8'h02, 4, 1'b1, 1'b1};
    vecs[3] = '{8'h03, 1, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 7, 1'b0, 1'b1};  // ACK match lands on the timeout edge
    vecs[5] = '{8'h00, 0, 1'b0, 1'b0};

    IN_DATA = '0;
    IN_VALID = 1'b0;
    ACK_ASYNC = 1'b0;
    RST = 1'b0;
    #1;
    chk_reset_vals();
    step();
    step();
    RST = 1'b1;
    idle_gap(2);

    for (int unsigned i = 0; i < 6; i++) begin
      xfer(vecs[i].data, vecs[i].ack_dly, vecs[i].vhold, vecs[i].exp_req);
      if (!vecs[i].vhold) idle_gap(1);
    end

    xfer(8'h5A, 2, 1'b0, 1'b1);
    #3;
    do_reset();
    idle_gap(1);

    for (int unsigned n = 0; n < 40; n++) begin
      w = BW'($urandom);
      d = $urandom_range(0, 7);
      h = 1'($urandom_range(0, 1));
      xfer(w, d, h, ~launches[0]);
      if (!h) idle_gap($urandom_range(1, 3));
    end

    // Timeout: ACK withheld, ERR exactly after 10 cycles in WAIT_ACK.
    idle_gap(1);
    IN_DATA = 8'hC3;
    IN_VALID = 1'b1;
    step();
    launches++;
    IN_VALID = 1'b0;
    for (int unsigned i = 1; i < TMO; i++) begin
      step();
      chk("tmo_err_early", {31'b0, ERR}, 0);
    end
    step();
    chk("tmo_err_set", {31'b0, ERR}, 1);
    for (int unsigned i = 0; i < 3; i++) begin
      IN_DATA = BW'($urandom);
      step();
      chk("tmo_data_held", {24'b0, TX_DATA}, 8'hC3);
      chk("tmo_not_ready", {31'b0, IN_READY}, 0);
    end
    ACK_ASYNC = launches[0];
    for (int unsigned i = 0; i < NS; i++) begin
      step();
      chk("tmo_no_done", {31'b0, DONE}, 0);
    end
    step();
    chk("tmo_late_done", {31'b0, DONE}, 1);
    chk("tmo_err_sticky", {31'b0, ERR}, 1);
    step();
    chk("tmo_done_cleared", {31'b0, DONE}, 0);
    chk("tmo_err_sticky2", {31'b0, ERR}, 1);
    do_reset();

    // Spurious ACK toggle in IDLE.
    idle_gap(2);
    ACK_ASYNC = 1'b1;
    for (int unsigned i = 0; i < NS; i++) begin
      step();
      chk("spur_err_early", {31'b0, ERR}, 0);
    end
    step();
    chk("spur_err_set", {31'b0, ERR}, 1);
    chk("spur_ready", {31'b0, IN_READY}, 1);
    chk("spur_req", {31'b0, TX_REQ}, 0);
    do_reset();
    idle_gap(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
